jk_excitation_encoder: RTL and testbench

JK_EXCITATION_ENCODER -- requirements
Module: jk_excitation_encoder

---
 rtl/jk_pkg.sv | 15 +
 rtl/jk_ff_bank.sv | 38 +++
 rtl/jk_excitation_encoder.sv | 126 ++++++++++++
 tb/tb_jk_excitation_encoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation encoder.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_APPLY,
        ST_CHECK
    } jk_state_e;

    // How excitation don't-cares are resolved.
    localparam bit DC_FILL_HOLD   = 1'b0;
    localparam bit DC_FILL_TOGGLE = 1'b1;

endpackage

// File: rtl/jk_ff_bank.sv
// WIDTH-bit edge-triggered JK register bank with enable and sync active-low reset.
module jk_ff_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Per bit: 00 hold, 10 set, 01 reset, 11 toggle.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = (j & ~q_q) | (~k & q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign qn     = ~q_q;
    assign q_next = q_d;

endmodule

// File: rtl/jk_excitation_encoder.sv
// Computes JK excitation for a requested target, applies it to a JK bank,
// then reports completion and whether the bank reached the target.
module jk_excitation_encoder
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter bit          DC_FILL = DC_FILL_HOLD
) (
    input  logic                         C,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             target,
    output logic [WIDTH-1:0]             J,
    output logic [WIDTH-1:0]             K,
    output logic [WIDTH-1:0]             Q,
    output logic [WIDTH-1:0]             Qn,
    output logic [$clog2(WIDTH+1)-1:0]   toggle_cnt,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    jk_state_e        state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] j_enc, k_enc, q_next, diff;
    logic [CW-1:0]    pop_cnt;

    jk_ff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk    (C),
        .rst_n  (rst_n),
        .en     (state_q == ST_APPLY),
        .j      (j_q),
        .k      (k_q),
        .q      (Q),
        .qn     (Qn),
        .q_next (q_next)
    );

    // Required transition determines one input; the other takes the fill value.
    always_comb begin
        j_enc = (~Q & tgt_q) | (Q & {WIDTH{DC_FILL}});
        k_enc = (Q & ~tgt_q) | (~Q & {WIDTH{DC_FILL}});
    end

    always_comb begin
        diff    = Q ^ target;
        pop_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + CW'(diff[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ENCODE;
                    tgt_d   = target;
                    cnt_d   = pop_cnt;
                end
            end
            ST_ENCODE: begin
                j_d     = j_enc;
                k_d     = k_enc;
                state_d = ST_APPLY;
            end
            // done/err are registered here so they are visible during CHECK.
            ST_APPLY: begin
                state_d = ST_CHECK;
                done_d  = 1'b1;
                err_d   = (q_next != tgt_q);
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign J          = j_q;
    assign K          = k_q;
    assign toggle_cnt = cnt_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_jk_excitation_encoder.sv
// Directed bench for jk_excitation_encoder: hold-fill (dut0) and toggle-fill (dut1).
module tb_jk_excitation_encoder;

    logic       C = 1'b0;
    logic       rst_n    [2];
    logic       in_valid [2];
    logic [7:0] target   [2];
    logic       in_ready [2];
    logic [7:0] J        [2];
    logic [7:0] K        [2];
    logic [7:0] Q        [2];
    logic [7:0] Qn       [2];
    logic [3:0] cnt      [2];
    logic       done     [2];
    logic       err      [2];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 C = ~C;

    jk_excitation_encoder #(
        .WIDTH   (8),
        .DC_FILL (1'b0)
    ) dut0 (
        .C (C), .rst_n (rst_n[0]), .in_valid (in_valid[0]), .in_ready (in_ready[0]),
        .target (target[0]), .J (J[0]), .K (K[0]), .Q (Q[0]), .Qn (Qn[0]),
        .toggle_cnt (cnt[0]), .done (done[0]), .err (err[0])
    );

    jk_excitation_encoder #(
        .WIDTH   (8),
        .DC_FILL (1'b1)
    ) dut1 (
        .C (C), .rst_n (rst_n[1]), .in_valid (in_valid[1]), .in_ready (in_ready[1]),
        .target (target[1]), .J (J[1]), .K (K[1]), .Q (Q[1]), .Qn (Qn[1]),
        .toggle_cnt (cnt[1]), .done (done[1]), .err (err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int s);
        @(negedge C);
        rst_n[s]    = 1'b0;
        in_valid[s] = 1'b0;
        repeat (2) @(negedge C);
        rst_n[s] = 1'b1;
        check_eq("rst_q",     Q[s],        32'h00);
        check_eq("rst_qn",    Qn[s],       32'hFF);
        check_eq("rst_j",     J[s],        32'h00);
        check_eq("rst_k",     K[s],        32'h00);
        check_eq("rst_ready", in_ready[s], 32'h1);
        check_eq("rst_done",  done[s],     32'h0);
        check_eq("rst_err",   err[s],      32'h0);
        check_eq("rst_cnt",   cnt[s],      32'h0);
    endtask

    // Called and returns on a negedge; every phase is a fixed cycle count.
    task automatic run_xact(input int s, input logic [7:0] t, input logic [7:0] q_before,
                            input logic [7:0] exp_j, input logic [7:0] exp_k,
                            input logic [7:0] exp_q, input logic [3:0] exp_cnt,
                            input bit inject, input logic [7:0] inj_t, input bit abort);
        logic [7:0] exp_qn;
        exp_qn = ~exp_q;
        check_eq("idle_ready", in_ready[s], 32'h1);
        in_valid[s] = 1'b1;
        target[s]   = t;
        @(posedge C);
        #1;
        in_valid[s] = 1'b0;
        target[s]   = 8'h00;
        @(negedge C);
        check_eq("enc_ready", in_ready[s], 32'h0);
        check_eq("enc_cnt",   cnt[s],      {28'h0, exp_cnt});
        check_eq("enc_q",     Q[s],        {24'h0, q_before});
        check_eq("enc_done",  done[s],     32'h0);
        if (inject) begin
            in_valid[s] = 1'b1;
            target[s]   = inj_t;
        end
        @(posedge C);
        #1;
        in_valid[s] = 1'b0;
        target[s]   = 8'h00;
        @(negedge C);
        check_eq("app_j",     J[s],        {24'h0, exp_j});
        check_eq("app_k",     K[s],        {24'h0, exp_k});
        check_eq("app_q",     Q[s],        {24'h0, q_before});
        check_eq("app_ready", in_ready[s], 32'h0);
        check_eq("app_done",  done[s],     32'h0);
        if (abort) begin
            rst_n[s] = 1'b0;
            @(negedge C);
            rst_n[s] = 1'b1;
            check_eq("abt_q",     Q[s],        32'h00);
            check_eq("abt_j",     J[s],        32'h00);
            check_eq("abt_k",     K[s],        32'h00);
            check_eq("abt_cnt",   cnt[s],      32'h0);
            check_eq("abt_ready", in_ready[s], 32'h1);
            check_eq("abt_done",  done[s],     32'h0);
            repeat (3) begin
                @(negedge C);
                check_eq("abt_nodone", done[s], 32'h0);
                check_eq("abt_q_idle", Q[s],    32'h00);
            end
            return;
        end
        @(negedge C);
        check_eq("chk_q",     Q[s],        {24'h0, exp_q});
        check_eq("chk_qn",    Qn[s],       {24'h0, exp_qn});
        check_eq("chk_done",  done[s],     32'h1);
        check_eq("chk_err",   err[s],      32'h0);
        check_eq("chk_ready", in_ready[s], 32'h0);
        check_eq("chk_j",     J[s],        {24'h0, exp_j});
        @(negedge C);
        check_eq("end_done",  done[s],     32'h0);
        check_eq("end_err",   err[s],      32'h0);
        check_eq("end_ready", in_ready[s], 32'h1);
        check_eq("end_cnt",   cnt[s],      {28'h0, exp_cnt});
        check_eq("end_q",     Q[s],        {24'h0, exp_q});
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]    = 1'b0;
            in_valid[i] = 1'b0;
            target[i]   = 8'h00;
        end
        do_reset(0);
        do_reset(1);

        // Hold fill: 00 -> A5 -> 3C -> 3C
        run_xact(0, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5, 4'd4, 1'b0, 8'h00, 1'b0);
        run_xact(0, 8'h3C, 8'hA5, 8'h18, 8'h81, 8'h3C, 4'd4, 1'b0, 8'h00, 1'b0);
        run_xact(0, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h3C, 4'd0, 1'b0, 8'h00, 1'b0);

        // Offer during ENCODE must be ignored
        do_reset(0);
        run_xact(0, 8'hF0, 8'h00, 8'hF0, 8'h00, 8'hF0, 4'd4, 1'b1, 8'h0F, 1'b0);

        // Reset during APPLY aborts, then a fresh transaction completes
        do_reset(0);
        run_xact(0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 4'd8, 1'b0, 8'h00, 1'b1);
        run_xact(0, 8'h81, 8'h00, 8'h81, 8'h00, 8'h81, 4'd2, 1'b0, 8'h00, 1'b0);

        // Toggle fill: 00 -> A5 -> 5A
        run_xact(1, 8'hA5, 8'h00, 8'hA5, 8'hFF, 8'hA5, 4'd4, 1'b0, 8'h00, 1'b0);
        run_xact(1, 8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'h5A, 4'd8, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
